// File: rtl/phase_freq_detector.sv
// rtl/phase_freq_detector.sv - counter-based phase/frequency detector for the ADPLL
module phase_freq_detector #(
    parameter int ERROR_WIDTH = 5,
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_THRESH = 1,
    parameter int LOCK_COUNT  = 16
) (
    input  logic                          gen_clk_i,
    input  logic                          reset_n_i,
    input  logic                          ref_clk_i,
    input  logic                          fb_clk_i,
    output logic signed [ERROR_WIDTH-1:0] error_o,
    output logic                          error_valid_o,
    output logic                          lock_o
);

    localparam int              MW       = ERROR_WIDTH - 1;
    localparam logic [MW-1:0]   MAX      = {MW{1'b1}};
    localparam logic [MW-1:0]   ONE      = MW'(1);
    localparam logic [7:0]      LOCK_MAX = 8'(LOCK_COUNT);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REF_LEAD = 2'd1,
        FB_LEAD  = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] ref_sync;
    logic [SYNC_STAGES-1:0] fb_sync;
    logic                   ref_last;
    logic                   fb_last;
    logic                   ref_p;
    logic                   fb_p;

    state_t                 state_q;
    state_t                 state_d;
    logic [MW-1:0]          cnt_q;
    logic [MW-1:0]          cnt_d;
    logic [MW-1:0]          cnt_inc;

    logic                   emit;
    logic                   emit_neg;
    logic [MW-1:0]          emit_mag;
    logic [ERROR_WIDTH-1:0] emit_val;
    logic                   in_lock;
    logic [7:0]             lock_cnt;

    // Synchronise both asynchronous clocks and remember the previous synchronised level
    always_ff @(posedge gen_clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ref_sync <= '0;
            fb_sync  <= '0;
            ref_last <= 1'b0;
            fb_last  <= 1'b0;
        end else begin
            ref_sync <= {ref_sync[SYNC_STAGES-2:0], ref_clk_i};
            fb_sync  <= {fb_sync[SYNC_STAGES-2:0], fb_clk_i};
            ref_last <= ref_sync[SYNC_STAGES-1];
            fb_last  <= fb_sync[SYNC_STAGES-1];
        end
    end

    assign ref_p = ref_sync[SYNC_STAGES-1] & ~ref_last;
    assign fb_p  = fb_sync[SYNC_STAGES-1] & ~fb_last;

    // Measurement state and saturating edge-distance counter
    always_ff @(posedge gen_clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign cnt_inc = (cnt_q == MAX) ? MAX : cnt_q + ONE;

    // Next state and emit decision; a repeated edge of the leading input is a cycle slip
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        emit     = 1'b0;
        emit_neg = 1'b0;
        emit_mag = '0;
        case (state_q)
            IDLE: begin
                if (ref_p && fb_p) begin
                    emit = 1'b1;
                end else if (ref_p) begin
                    state_d = REF_LEAD;
                    cnt_d   = ONE;
                end else if (fb_p) begin
                    state_d = FB_LEAD;
                    cnt_d   = ONE;
                end
            end
            REF_LEAD: begin
                if (fb_p) begin
                    emit     = 1'b1;
                    emit_mag = cnt_q;
                    if (ref_p) begin
                        cnt_d = ONE;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (ref_p) begin
                    emit     = 1'b1;
                    emit_mag = MAX;
                    cnt_d    = ONE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            FB_LEAD: begin
                emit_neg = 1'b1;
                if (ref_p) begin
                    emit     = 1'b1;
                    emit_mag = cnt_q;
                    if (fb_p) begin
                        cnt_d = ONE;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (fb_p) begin
                    emit     = 1'b1;
                    emit_mag = MAX;
                    cnt_d    = ONE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign emit_val = emit_neg ? (ERROR_WIDTH'(0) - {1'b0, emit_mag}) : {1'b0, emit_mag};
    assign in_lock  = (int'(emit_mag) <= LOCK_THRESH);

    // Register the signed error and its one-cycle strobe
    always_ff @(posedge gen_clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            error_o       <= '0;
            error_valid_o <= 1'b0;
        end else begin
            error_valid_o <= emit;
            if (emit) begin
                error_o <= emit_val;
            end
        end
    end

    // Count consecutive in-threshold errors; lock_o follows the count one cycle later
    always_ff @(posedge gen_clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            lock_cnt <= '0;
            lock_o   <= 1'b0;
        end else begin
            if (emit) begin
                if (!in_lock) begin
                    lock_cnt <= '0;
                end else if (lock_cnt >= LOCK_MAX) begin
                    lock_cnt <= LOCK_MAX;
                end else begin
                    lock_cnt <= lock_cnt + 8'd1;
                end
            end
            lock_o <= (lock_cnt == LOCK_MAX);
        end
    end

endmodule

// File: tb/tb_phase_freq_detector.sv
// tb/tb_phase_freq_detector.sv - self-checking bench for phase_freq_detector
module tb_phase_freq_detector;

    localparam int EW   = 5;
    localparam int SS   = 2;
    localparam int LT   = 1;
    localparam int LC   = 16;
    localparam int MAXV = 15;
    localparam int NMAX = 2000;

    logic                 gen_clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic                 ref_clk = 1'b0;
    logic                 fb_clk  = 1'b0;
    logic signed [EW-1:0] error;
    logic                 error_valid;
    logic                 lock;

    int errors = 0;
    int checks = 0;

    bit ref_w [NMAX];
    bit fb_w  [NMAX];
    bit obs_lock [NMAX];
    bit exp_lock [NMAX];
    int obs_cyc [$];
    int obs_val [$];
    int exp_cyc [$];
    int exp_val [$];

    always #5 gen_clk = ~gen_clk;

    phase_freq_detector #(
        .ERROR_WIDTH(EW),
        .SYNC_STAGES(SS),
        .LOCK_THRESH(LT),
        .LOCK_COUNT (LC)
    ) dut (
        .gen_clk_i    (gen_clk),
        .reset_n_i    (reset_n),
        .ref_clk_i    (ref_clk),
        .fb_clk_i     (fb_clk),
        .error_o      (error),
        .error_valid_o(error_valid),
        .lock_o       (lock)
    );

    task automatic do_reset();
        reset_n = 1'b0;
        ref_clk = 1'b0;
        fb_clk  = 1'b0;
        repeat (4) @(posedge gen_clk);
        @(negedge gen_clk);
        reset_n = 1'b1;
        repeat (2) @(posedge gen_clk);
    endtask

    task automatic clear_waves();
        for (int i = 0; i < NMAX; i++) begin
            ref_w[i] = 1'b0;
            fb_w[i]  = 1'b0;
        end
    endtask

    task automatic add_pulse(input bit is_ref, input int rise, input int high);
        for (int i = rise; i < rise + high && i < NMAX; i++) begin
            if (is_ref) ref_w[i] = 1'b1;
            else        fb_w[i]  = 1'b1;
        end
    endtask

    // Plays the waveform tables cycle by cycle and records every strobe and the lock level.
    task automatic run_waves(input int n);
        obs_cyc.delete();
        obs_val.delete();
        for (int c = 0; c < n; c++) begin
            @(posedge gen_clk);
            #1;
            ref_clk = ref_w[c];
            fb_clk  = fb_w[c];
            @(negedge gen_clk);
            if (error_valid === 1'b1) begin
                obs_cyc.push_back(c);
                obs_val.push_back(int'(error));
            end
            obs_lock[c] = lock;
        end
        ref_clk = 1'b0;
        fb_clk  = 1'b0;
    endtask

    // Reference model: timestamps of rising edges, the open measurement's start time,
    // and the distance between edges in cycles, clipped to MAXV.
    task automatic build_model(input int n);
        int  open_src;
        int  t_open;
        int  lc;
        int  v;
        int  s;
        int  mag;
        bit  emit;
        bit  r;
        bit  f;
        bit  pr;
        bit  pf;
        open_src = 0;
        t_open   = 0;
        lc       = 0;
        pr       = 1'b0;
        pf       = 1'b0;
        exp_cyc.delete();
        exp_val.delete();
        for (int c = 0; c < n; c++) exp_lock[c] = 1'b0;
        for (int c = 0; c < n; c++) begin
            r    = ref_w[c] && !pr;
            f    = fb_w[c] && !pf;
            pr   = ref_w[c];
            pf   = fb_w[c];
            emit = 1'b0;
            v    = 0;
            if (r || f) begin
                if (open_src == 0) begin
                    if (r && f) begin
                        emit = 1'b1;
                        v    = 0;
                    end else begin
                        open_src = r ? 1 : 2;
                        t_open   = c;
                    end
                end else if (open_src == 1) begin
                    emit = 1'b1;
                    if (f) begin
                        v = (c - t_open > MAXV) ? MAXV : c - t_open;
                        if (r) t_open = c;
                        else   open_src = 0;
                    end else begin
                        v      = MAXV;
                        t_open = c;
                    end
                end else begin
                    emit = 1'b1;
                    if (r) begin
                        v = (c - t_open > MAXV) ? -MAXV : -(c - t_open);
                        if (f) t_open = c;
                        else   open_src = 0;
                    end else begin
                        v      = -MAXV;
                        t_open = c;
                    end
                end
            end
            if (emit) begin
                s   = c + SS + 1;
                mag = (v < 0) ? -v : v;
                if (mag <= LT) lc = (lc + 1 > LC) ? LC : lc + 1;
                else           lc = 0;
                if (s < n) begin
                    exp_cyc.push_back(s);
                    exp_val.push_back(v);
                end
                for (int j = s + 1; j < n; j++) exp_lock[j] = (lc == LC);
            end
        end
    endtask

    task automatic test_reset();
        int strobes;
        reset_n = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge gen_clk);
            #1;
            ref_clk = i[0];
            fb_clk  = i[1];
            @(negedge gen_clk);
            checks++;
            if (error !== '0 || error_valid !== 1'b0 || lock !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold cycle %0d: error=%0d valid=%b lock=%b, required 0/0/0", i, error, error_valid, lock);
            end
        end
        ref_clk = 1'b0;
        fb_clk  = 1'b0;
        repeat (3) @(posedge gen_clk);
        @(negedge gen_clk);
        reset_n = 1'b1;
        clear_waves();
        add_pulse(1'b1, 2, 10);
        add_pulse(1'b0, 6, 10);
        add_pulse(1'b1, 22, 10);
        run_waves(30);
        checks++;
        if (obs_val.size() !== 1 || error !== 5'sd4) begin
            errors++;
            $display("FAIL reset_pre_measure: strobes=%0d error=%0d, required 1 strobe and error 4", obs_val.size(), error);
        end
        #2;
        reset_n = 1'b0;
        fb_clk  = 1'b1;
        #1;
        checks++;
        if (error !== '0 || error_valid !== 1'b0 || lock !== 1'b0) begin
            errors++;
            $display("FAIL reset_async_clear: error=%0d valid=%b lock=%b, required 0/0/0", error, error_valid, lock);
        end
        repeat (3) @(posedge gen_clk);
        @(negedge gen_clk);
        reset_n = 1'b1;
        strobes = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge gen_clk);
            if (error_valid === 1'b1) strobes++;
        end
        fb_clk = 1'b0;
        checks++;
        if (strobes !== 0 || error !== '0) begin
            errors++;
            $display("FAIL reset_no_strobe_after_release: strobes=%0d error=%0d, required 0 and 0", strobes, error);
        end
    endtask

    task automatic test_ref_lead();
        do_reset();
        clear_waves();
        for (int i = 0; i < 5; i++) begin
            add_pulse(1'b1, 5 + 20 * i, 10);
            add_pulse(1'b0, 8 + 20 * i, 10);
        end
        run_waves(120);
        checks++;
        if (obs_cyc.size() !== 5) begin
            errors++;
            $display("FAIL ref_lead_count: got %0d strobes, required 5", obs_cyc.size());
        end
        for (int i = 0; i < 5 && i < obs_cyc.size(); i++) begin
            checks++;
            if (obs_val[i] !== 3 || obs_cyc[i] !== 8 + 20 * i + SS + 1) begin
                errors++;
                $display("FAIL ref_lead_%0d: value %0d at cycle %0d, required 3 at cycle %0d", i, obs_val[i], obs_cyc[i], 8 + 20 * i + SS + 1);
            end
        end
    endtask

    task automatic test_fb_lead();
        do_reset();
        clear_waves();
        for (int i = 0; i < 4; i++) begin
            add_pulse(1'b0, 5 + 20 * i, 10);
            add_pulse(1'b1, 10 + 20 * i, 10);
        end
        run_waves(100);
        checks++;
        if (obs_cyc.size() !== 4 || error !== 5'b11011) begin
            errors++;
            $display("FAIL fb_lead_count: %0d strobes, error=%b, required 4 strobes and 11011", obs_cyc.size(), error);
        end
        for (int i = 0; i < 4 && i < obs_cyc.size(); i++) begin
            checks++;
            if (obs_val[i] !== -5 || obs_cyc[i] !== 10 + 20 * i + SS + 1) begin
                errors++;
                $display("FAIL fb_lead_%0d: value %0d at cycle %0d, required -5 at cycle %0d", i, obs_val[i], obs_cyc[i], 10 + 20 * i + SS + 1);
            end
        end
    endtask

    task automatic test_coincident();
        do_reset();
        clear_waves();
        for (int i = 0; i < 4; i++) begin
            add_pulse(1'b1, 5 + 20 * i, 10);
            add_pulse(1'b0, 5 + 20 * i, 10);
        end
        run_waves(100);
        checks++;
        if (obs_cyc.size() !== 4) begin
            errors++;
            $display("FAIL coincident_count: got %0d strobe cycles, required 4", obs_cyc.size());
        end
        for (int i = 0; i < 4 && i < obs_cyc.size(); i++) begin
            checks++;
            if (obs_val[i] !== 0 || obs_cyc[i] !== 5 + 20 * i + SS + 1) begin
                errors++;
                $display("FAIL coincident_%0d: value %0d at cycle %0d, required 0 at cycle %0d", i, obs_val[i], obs_cyc[i], 5 + 20 * i + SS + 1);
            end
        end
    endtask

    task automatic test_saturation_slip();
        int want_val [3];
        int want_cyc [3];
        want_val = '{15, 15, 2};
        want_cyc = '{45 + SS + 1, 100 + SS + 1, 102 + SS + 1};
        do_reset();
        clear_waves();
        add_pulse(1'b1, 5, 10);
        add_pulse(1'b0, 45, 10);
        add_pulse(1'b1, 70, 10);
        add_pulse(1'b1, 100, 10);
        add_pulse(1'b0, 102, 10);
        run_waves(130);
        checks++;
        if (obs_cyc.size() !== 3) begin
            errors++;
            $display("FAIL sat_slip_count: got %0d strobes, required 3", obs_cyc.size());
        end
        for (int i = 0; i < 3 && i < obs_cyc.size(); i++) begin
            checks++;
            if (obs_val[i] !== want_val[i] || obs_cyc[i] !== want_cyc[i]) begin
                errors++;
                $display("FAIL sat_slip_%0d: value %0d at cycle %0d, required %0d at cycle %0d", i, obs_val[i], obs_cyc[i], want_val[i], want_cyc[i]);
            end
        end
    endtask

    task automatic test_lock();
        int d;
        int base;
        int s16;
        int s17;
        int bad;
        int first_bad;
        do_reset();
        clear_waves();
        for (int i = 0; i < 17; i++) begin
            base = 10 + 20 * i;
            d    = (i == 16) ? 4 : ((i % 3 == 0) ? 0 : ((i % 3 == 1) ? 1 : -1));
            add_pulse(1'b1, base, 10);
            add_pulse(1'b0, base + d, 10);
        end
        run_waves(380);
        build_model(380);
        checks++;
        if (obs_cyc.size() !== 17) begin
            errors++;
            $display("FAIL lock_strobe_count: got %0d, required 17", obs_cyc.size());
        end else begin
            s16 = obs_cyc[15];
            s17 = obs_cyc[16];
            checks++;
            if (obs_lock[s16] !== 1'b0 || obs_lock[s16 + 1] !== 1'b1) begin
                errors++;
                $display("FAIL lock_rise: lock=%b,%b around 16th strobe, required 0,1", obs_lock[s16], obs_lock[s16 + 1]);
            end
            checks++;
            if (obs_val[16] !== 4 || obs_lock[s17] !== 1'b1 || obs_lock[s17 + 1] !== 1'b0) begin
                errors++;
                $display("FAIL lock_fall: value %0d lock=%b,%b, required 4 and 1,0", obs_val[16], obs_lock[s17], obs_lock[s17 + 1]);
            end
        end
        bad       = 0;
        first_bad = -1;
        for (int c = 0; c < 380; c++) begin
            if (obs_lock[c] !== exp_lock[c]) begin
                bad++;
                if (first_bad < 0) first_bad = c;
            end
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL lock_trace: %0d cycles differ, first at %0d (lock=%b, required %b)", bad, first_bad, obs_lock[first_bad], exp_lock[first_bad]);
        end
    endtask

    task automatic test_random();
        int n;
        int c;
        int dwell;
        bit lvl;
        int bad;
        int first_bad;
        n = 400;
        for (int round = 0; round < 5; round++) begin
            do_reset();
            clear_waves();
            for (int sig = 0; sig < 2; sig++) begin
                c   = $urandom_range(0, 10);
                lvl = 1'b0;
                while (c < n - 15) begin
                    dwell = $urandom_range(3, 14 + 8 * round);
                    lvl   = ~lvl;
                    if (lvl) add_pulse(sig == 0, c, (c + dwell > n - 15) ? n - 15 - c : dwell);
                    c += dwell;
                end
            end
            run_waves(n);
            build_model(n);
            checks++;
            if (obs_cyc.size() !== exp_cyc.size()) begin
                errors++;
                $display("FAIL random_%0d_count: got %0d strobes, required %0d", round, obs_cyc.size(), exp_cyc.size());
            end
            bad       = 0;
            first_bad = -1;
            for (int i = 0; i < obs_cyc.size() && i < exp_cyc.size(); i++) begin
                if (obs_cyc[i] !== exp_cyc[i] || obs_val[i] !== exp_val[i]) begin
                    bad++;
                    if (first_bad < 0) first_bad = i;
                end
            end
            checks++;
            if (bad !== 0) begin
                errors++;
                $display("FAIL random_%0d_strobes: %0d differ, first #%0d value %0d at %0d, required %0d at %0d", round, bad, first_bad, obs_val[first_bad], obs_cyc[first_bad], exp_val[first_bad], exp_cyc[first_bad]);
            end
            bad = 0;
            for (int k = 0; k < n; k++) if (obs_lock[k] !== exp_lock[k]) bad++;
            checks++;
            if (bad !== 0) begin
                errors++;
                $display("FAIL random_%0d_lock: %0d cycles of lock differ from model, required 0", round, bad);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ref_lead();
        test_fb_lead();
        test_coincident();
        test_saturation_slip();
        test_lock();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
